// File: rtl/wr_bram_patch_pkg.sv
// Patch geometry and writer state encoding, shared by the port-A patch writer and the port-B patch reader.
package wr_bram_patch_pkg;

   localparam int unsigned BRAM_PATCH_NUM        = 8;
   localparam int unsigned BRAM_PATCH_DATA_WIDTH = 480;
   localparam int unsigned BRAM_PATCH_ADDR_WIDTH = 13;
   localparam int unsigned WR_BRAM_PATCH_CNT_W   = 4;

   typedef enum logic [1:0] {
      WR_BRAM_PATCH_IDLE = 2'd0,
      WR_BRAM_PATCH_WR   = 2'd1,
      WR_BRAM_PATCH_DONE = 2'd2
   } wr_bram_patch_state_e;

endpackage

// File: rtl/wr_bram_patch_if.sv
// Producer word stream plus BRAM port-A write bus of the patch writer.
// The flush line exists only when WR_BRAM_PATCH_ZERO_FILL_EN is defined.
interface wr_bram_patch_if
   import wr_bram_patch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = BRAM_PATCH_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = BRAM_PATCH_ADDR_WIDTH
);

   logic [DATA_WIDTH-1:0] wr_data_patch_din;
   logic                  wr_data_patch_valid;
   logic                  wr_data_patch_ready;
`ifdef WR_BRAM_PATCH_ZERO_FILL_EN
   logic                  wr_data_patch_flush;
`endif
   logic                  wr_data_bram_patch_ena;
   logic                  wr_data_bram_patch_wea;
   logic [ADDR_WIDTH-1:0] wr_data_bram_patch_addra;
   logic [DATA_WIDTH-1:0] wr_data_bram_patch_dina;
   logic                  wr_data_bram_patch_last;

   modport master (
`ifdef WR_BRAM_PATCH_ZERO_FILL_EN
      output wr_data_patch_flush,
`endif
      output wr_data_patch_din,
      output wr_data_patch_valid,
      input  wr_data_patch_ready,
      input  wr_data_bram_patch_ena,
      input  wr_data_bram_patch_wea,
      input  wr_data_bram_patch_addra,
      input  wr_data_bram_patch_dina,
      input  wr_data_bram_patch_last
   );

   modport slave (
`ifdef WR_BRAM_PATCH_ZERO_FILL_EN
      input  wr_data_patch_flush,
`endif
      input  wr_data_patch_din,
      input  wr_data_patch_valid,
      output wr_data_patch_ready,
      output wr_data_bram_patch_ena,
      output wr_data_bram_patch_wea,
      output wr_data_bram_patch_addra,
      output wr_data_bram_patch_dina,
      output wr_data_bram_patch_last
   );

endinterface

// File: rtl/wr_bram_patch.sv
// Writes one PATCH_NUM-word patch into the patch BRAM via port A at ith_offset + k.
// Optional WR_BRAM_PATCH_ZERO_FILL_EN adds a flush that zero-fills the rest of the patch.
module wr_bram_patch
   import wr_bram_patch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = BRAM_PATCH_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = BRAM_PATCH_ADDR_WIDTH,
   parameter int unsigned PATCH_NUM  = BRAM_PATCH_NUM
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_data_bottom,
   input  logic [ADDR_WIDTH-1:0] wr_data_bram_patch_ith_offset,
   wr_bram_patch_if.slave        bus,
   output logic                  wr_data_bram_patch_done,
   output logic                  wr_data_bram_patch_busy
);

   localparam int unsigned          CNT_W    = WR_BRAM_PATCH_CNT_W;
   localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(PATCH_NUM - 1);

   wr_bram_patch_state_e  state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] off_q, off_d;
   logic                  fill_q, fill_d;
   logic                  ready_q, ready_d;
   logic                  ena_q, ena_d;
   logic [ADDR_WIDTH-1:0] addra_q, addra_d;
   logic [DATA_WIDTH-1:0] dina_q, dina_d;
   logic                  last_q, last_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  flush_c;
   logic                  accept_c;
   logic                  write_c;

`ifdef WR_BRAM_PATCH_ZERO_FILL_EN
   assign flush_c = bus.wr_data_patch_flush;
`else
   assign flush_c = 1'b0;
`endif

   // ready_q is only ever high in WR outside zero-fill, so it doubles as the accept qualifier
   assign accept_c = bus.wr_data_patch_valid & ready_q;
   assign write_c  = accept_c | fill_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      off_d   = off_q;
      fill_d  = fill_q;
      ena_d   = 1'b0;
      addra_d = addra_q;
      dina_d  = dina_q;
      last_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         WR_BRAM_PATCH_IDLE: begin
            if (wr_data_bottom) begin
               off_d   = wr_data_bram_patch_ith_offset;
               cnt_d   = '0;
               fill_d  = 1'b0;
               state_d = WR_BRAM_PATCH_WR;
            end
         end
         WR_BRAM_PATCH_WR: begin
            if (write_c) begin
               ena_d   = 1'b1;
               addra_d = ADDR_WIDTH'(off_q + ADDR_WIDTH'(cnt_q));
               dina_d  = fill_q ? '0 : bus.wr_data_patch_din;
               last_d  = (cnt_q == LAST_CNT);
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) state_d = WR_BRAM_PATCH_DONE;
            end
            if (flush_c && ready_q) fill_d = 1'b1;
         end
         WR_BRAM_PATCH_DONE: begin
            done_d  = 1'b1;
            state_d = WR_BRAM_PATCH_IDLE;
         end
         default: state_d = WR_BRAM_PATCH_IDLE;
      endcase
      ready_d = (state_d == WR_BRAM_PATCH_WR) && !fill_d;
      busy_d  = (state_d != WR_BRAM_PATCH_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WR_BRAM_PATCH_IDLE;
         cnt_q   <= '0;
         off_q   <= '0;
         fill_q  <= 1'b0;
         ready_q <= 1'b0;
         ena_q   <= 1'b0;
         addra_q <= '0;
         dina_q  <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
         fill_q  <= fill_d;
         ready_q <= ready_d;
         ena_q   <= ena_d;
         addra_q <= addra_d;
         dina_q  <= dina_d;
         last_q  <= last_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.wr_data_patch_ready      = ready_q;
   assign bus.wr_data_bram_patch_ena   = ena_q;
   assign bus.wr_data_bram_patch_wea   = ena_q;
   assign bus.wr_data_bram_patch_addra = addra_q;
   assign bus.wr_data_bram_patch_dina  = dina_q;
   assign bus.wr_data_bram_patch_last  = last_q;
   assign wr_data_bram_patch_done      = done_q;
   assign wr_data_bram_patch_busy      = busy_q;

endmodule

// File: tb/tb_wr_bram_patch.sv
// Randomized bench for wr_bram_patch: expected BRAM writes are the list (offset+k mod 8192, word k).
module tb_wr_bram_patch;
   import wr_bram_patch_pkg::*;

   localparam int unsigned DW = BRAM_PATCH_DATA_WIDTH;
   localparam int unsigned AW = BRAM_PATCH_ADDR_WIDTH;
   localparam int unsigned N  = BRAM_PATCH_NUM;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          bottom = 1'b0;
   logic [AW-1:0] offset = '0;
   logic          done;
   logic          busy;
`ifdef WR_BRAM_PATCH_ZERO_FILL_EN
   logic          flush  = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int start_cyc = 0;

   logic [DW-1:0] words [N];

   int            acc_q [$];
   logic [AW-1:0] oaddr [$];
   logic [DW-1:0] odata [$];
   bit            olast [$];
   bit            owea  [$];
   int            ocyc  [$];
   int            done_q[$];

   wr_bram_patch_if bus ();

`ifdef WR_BRAM_PATCH_ZERO_FILL_EN
   assign bus.wr_data_patch_flush = flush;
`endif

   wr_bram_patch dut (
      .clk                           (clk),
      .rst_n                         (rst_n),
      .wr_data_bottom                (bottom),
      .wr_data_bram_patch_ith_offset (offset),
      .bus                           (bus),
      .wr_data_bram_patch_done       (done),
      .wr_data_bram_patch_busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // passive monitor: every handshake, strobe and done pulse, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.wr_data_patch_valid && bus.wr_data_patch_ready) acc_q.push_back(cyc);
         if (bus.wr_data_bram_patch_ena) begin
            oaddr.push_back(bus.wr_data_bram_patch_addra);
            odata.push_back(bus.wr_data_bram_patch_dina);
            olast.push_back(bus.wr_data_bram_patch_last);
            owea.push_back(bus.wr_data_bram_patch_wea);
            ocyc.push_back(cyc);
         end
         if (done) done_q.push_back(cyc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      acc_q.delete(); oaddr.delete(); odata.delete(); olast.delete();
      owea.delete(); ocyc.delete(); done_q.delete();
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] w;
      for (int i = 0; i < int'(DW / 32); i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic rnd_words();
      for (int k = 0; k < int'(N); k++) words[k] = rnd_word();
   endtask

   task automatic start_patch(input int off);
      bottom    = 1'b1;
      offset    = AW'(off);
      start_cyc = cyc;
      step();
      bottom    = 1'b0;
   endtask

   // sends n words, optional valid gap before index gap_at, stray start at pulse_at, flush with word flush_at
   task automatic send(input int n, input int gap_at, input int gap_len, input int pulse_at, input int flush_at);
      int t;
      for (int k = 0; k < n; k++) begin
         if (k == gap_at) begin
            bus.wr_data_patch_valid = 1'b0;
            repeat (gap_len) step();
         end
         bus.wr_data_patch_valid = 1'b1;
         bus.wr_data_patch_din   = words[k];
         if (k == pulse_at) begin
            bottom = 1'b1;
            offset = AW'(40);
         end
`ifdef WR_BRAM_PATCH_ZERO_FILL_EN
         flush = (k == flush_at);
`endif
         t = 0;
         while (!bus.wr_data_patch_ready && t < 50) begin
            step();
            t++;
         end
         total++;
         if (t >= 50) begin
            bad++;
            $display("FAIL handshake word %0d: ready stayed low %0d cycles, required within 50", k, t);
         end
         step();
         bottom = 1'b0;
`ifdef WR_BRAM_PATCH_ZERO_FILL_EN
         flush = 1'b0;
`endif
      end
      bus.wr_data_patch_valid = 1'b0;
   endtask

   // optional lone flush, then junk valid words that must never be accepted
   task automatic tail(input bit do_flush);
`ifdef WR_BRAM_PATCH_ZERO_FILL_EN
      if (do_flush) begin
         flush = 1'b1;
         step();
         flush = 1'b0;
      end
`else
      if (do_flush) $display("note: flush requested without zero-fill build");
`endif
      bus.wr_data_patch_valid = 1'b1;
      bus.wr_data_patch_din   = rnd_word();
      repeat (4) step();
      bus.wr_data_patch_valid = 1'b0;
   endtask

   task automatic check_patch(input string name, input int off, input int ndata);
      int t;
      int m;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      t = 0;
      while (done_q.size() == 0 && t < 200) begin
         step();
         t++;
      end
      repeat (3) step();
      total++;
      if (done_q.size() != 1) begin
         bad++;
         $display("FAIL %s done_pulses got=%0d want=1", name, done_q.size());
      end
      total++;
      if (oaddr.size() != int'(N)) begin
         bad++;
         $display("FAIL %s strobe_count got=%0d want=%0d", name, oaddr.size(), N);
      end
      total++;
      if (acc_q.size() != ndata) begin
         bad++;
         $display("FAIL %s accept_count got=%0d want=%0d", name, acc_q.size(), ndata);
      end
      m = (oaddr.size() < int'(N)) ? oaddr.size() : int'(N);
      for (int k = 0; k < m; k++) begin
         ea = AW'((off + k) % 8192);
         ed = (k < ndata) ? words[k] : '0;
         total++;
         if (oaddr[k] !== ea || owea[k] !== 1'b1 || olast[k] !== (k == int'(N) - 1)) begin
            bad++;
            $display("FAIL %s strobe%0d addr/wea/last got=%0d/%0b/%0b want=%0d/1/%0b",
                     name, k, oaddr[k], owea[k], olast[k], ea, (k == int'(N) - 1));
         end
         total++;
         if (odata[k] !== ed) begin
            bad++;
            $display("FAIL %s strobe%0d dina got=%h want=%h", name, k, odata[k], ed);
         end
         if (k < ndata && k < acc_q.size()) begin
            total++;
            if (ocyc[k] != acc_q[k] + 1) begin
               bad++;
               $display("FAIL %s latency%0d strobe_cyc=%0d want=%0d", name, k, ocyc[k], acc_q[k] + 1);
            end
         end
      end
      if (done_q.size() > 0 && m == int'(N)) begin
         total++;
         if (done_q[0] != ocyc[N-1] + 1) begin
            bad++;
            $display("FAIL %s done_after_last done_cyc=%0d want=%0d", name, done_q[0], ocyc[N-1] + 1);
         end
      end
      total++;
      if (busy !== 1'b0 || bus.wr_data_patch_ready !== 1'b0) begin
         bad++;
         $display("FAIL %s idle_after busy/ready got=%0b/%0b want=0/0", name, busy, bus.wr_data_patch_ready);
      end
   endtask

   task automatic check_all_zero(input string name);
      logic [DW+AW+6:0] got;
      got = {bus.wr_data_patch_ready, bus.wr_data_bram_patch_ena, bus.wr_data_bram_patch_wea,
             bus.wr_data_bram_patch_addra, bus.wr_data_bram_patch_dina, bus.wr_data_bram_patch_last,
             done, busy};
      total++;
      if (got !== '0) begin
         bad++;
         $display("FAIL %s outputs got=%h want=0", name, got);
      end
   endtask

   task automatic test_reset();
      bus.wr_data_patch_valid = 1'b0;
      bus.wr_data_patch_din   = '0;
      repeat (2) step();
      check_all_zero("reset_asserted");
      rst_n = 1'b1;
      step();
      check_all_zero("reset_released");
      clear_obs();
      bus.wr_data_patch_valid = 1'b1;
      bus.wr_data_patch_din   = rnd_word();
      repeat (3) step();
      bus.wr_data_patch_valid = 1'b0;
      step();
      total++;
      if (oaddr.size() != 0 || acc_q.size() != 0) begin
         bad++;
         $display("FAIL idle_valid strobes/accepts got=%0d/%0d want=0/0", oaddr.size(), acc_q.size());
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < int'(N); k++) words[k] = DW'(k + 1);
      clear_obs();
      start_patch(16);
      total++;
      if (busy !== 1'b1 || bus.wr_data_patch_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b in_wr busy/ready got=%0b/%0b want=1/1", busy, bus.wr_data_patch_ready);
      end
      send(N, -1, 0, -1, -1);
      tail(1'b0);
      check_patch("b2b", 16, N);
      total++;
      if (done_q.size() == 0 || done_q[0] - start_cyc != int'(N) + 2) begin
         bad++;
         $display("FAIL b2b patch_time got=%0d want=%0d", (done_q.size() > 0) ? done_q[0] - start_cyc : -1, N + 2);
      end
   endtask

   task automatic test_gap();
      rnd_words();
      clear_obs();
      start_patch(16);
      send(N, 4, 3, -1, -1);
      tail(1'b0);
      check_patch("gap", 16, N);
      total++;
      if (ocyc.size() < 5 || ocyc[4] - ocyc[3] != 4) begin
         bad++;
         $display("FAIL gap spacing got=%0d want=4", (ocyc.size() >= 5) ? ocyc[4] - ocyc[3] : -1);
      end
   endtask

   task automatic test_wrap();
      rnd_words();
      clear_obs();
      start_patch(8188);
      send(N, -1, 0, -1, -1);
      tail(1'b0);
      check_patch("wrap", 8188, N);
   endtask

   task automatic test_ignore_start();
      rnd_words();
      clear_obs();
      start_patch(0);
      send(N, -1, 0, 2, -1);
      tail(1'b0);
      check_patch("ignore_start", 0, N);
      rnd_words();
      clear_obs();
      start_patch(40);
      send(N, -1, 0, -1, -1);
      tail(1'b0);
      check_patch("restart_40", 40, N);
   endtask

   task automatic test_reset_mid();
      rnd_words();
      clear_obs();
      start_patch(0);
      send(3, -1, 0, -1, -1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_mid");
      step();
      rst_n = 1'b1;
      clear_obs();
      repeat (12) step();
      total++;
      if (done_q.size() != 0 || oaddr.size() != 0) begin
         bad++;
         $display("FAIL reset_mid abandoned done/strobes got=%0d/%0d want=0/0", done_q.size(), oaddr.size());
      end
      rnd_words();
      clear_obs();
      start_patch(0);
      send(N, -1, 0, -1, -1);
      tail(1'b0);
      check_patch("after_reset", 0, N);
   endtask

`ifdef WR_BRAM_PATCH_ZERO_FILL_EN
   task automatic test_flush();
      rnd_words();
      clear_obs();
      start_patch(24);
      send(5, -1, 0, -1, -1);
      tail(1'b1);
      check_patch("flush_alone", 24, 5);
      rnd_words();
      clear_obs();
      start_patch(24);
      send(5, -1, 0, -1, 4);
      tail(1'b0);
      check_patch("flush_coincide", 24, 5);
      rnd_words();
      clear_obs();
      start_patch(24);
      send(N, -1, 0, -1, N - 1);
      tail(1'b0);
      check_patch("flush_last", 24, N);
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_gap();
      test_wrap();
      test_ignore_start();
      test_reset_mid();
`ifdef WR_BRAM_PATCH_ZERO_FILL_EN
      test_flush();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
